hazard_fwd_ctrl: RTL and testbench

- Central hazard/forwarding scheduler for the 5-stage pipeline, using the Tuse/Tnew scheme.
- Tracks destination-register records through E/M/W internally and compares them against D-stage and E-stage source registers.
- Drives the select inputs of the D, ALU-operand and DM-write-data forwarding muxes, plus a global stall.
- Sits beside the decoder; consumes per-instruction control from D and the rs/rt fields that advance with the pipeline.

---
 rtl/hazard_fwd_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: Tuse/Tnew hazard and forwarding scheduler for the 5-stage pipeline.
// Tracks destination records through E/M/W, drives the D, ALU-operand and DM-write-data
// forward selects and a global stall.
// Optional: define MD_STALL_EN to add the mult/div busy-counter stall (md_startE, md_useD).
module hazard_fwd_ctrl #(
    parameter int unsigned RW = 5,
    parameter int unsigned TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] rsD,
    input  logic [RW-1:0] rtD,
    input  logic [TW-1:0] tuse_rs,
    input  logic [TW-1:0] tuse_rt,
    input  logic [RW-1:0] a3D,
    input  logic [TW-1:0] tnewD,
    input  logic [1:0]    srcD,
`ifdef MD_STALL_EN
    input  logic [1:0]    md_startE,
    input  logic          md_useD,
`endif
    output logic          stall,
    output logic [2:0]    mf_d_1_sel,
    output logic [2:0]    mf_d_2_sel,
    output logic [2:0]    mf_alu_a_sel,
    output logic [2:0]    mf_alu_b_sel,
    output logic [2:0]    mf_dmi_sel
);

    localparam logic [2:0] SelRf   = 3'b000;
    localparam logic [2:0] SelMalu = 3'b001;
    localparam logic [2:0] SelMpc  = 3'b010;
    localparam logic [2:0] SelWd   = 3'b011;
    localparam logic [2:0] SelEpc  = 3'b100;
    localparam logic [1:0] SrcPc8  = 2'b10;

    // E record is complete; M and W keep only the fields that are ever consulted.
    logic [RW-1:0] e_a3, e_rs, e_rt;
    logic [TW-1:0] e_tnew;
    logic [1:0]    e_src;
    logic [RW-1:0] m_a3, m_rt;
    logic [TW-1:0] m_tnew;
    logic [1:0]    m_src;
    logic [RW-1:0] w_a3;
    logic          md_stall;

    // Register 0 is hardwired, so it never counts as a match.
    function automatic logic hit(input logic [RW-1:0] a3, input logic [RW-1:0] s);
        return (a3 != '0) && (a3 == s);
    endfunction

    function automatic logic src_stall(input logic [RW-1:0] s, input logic [TW-1:0] tuse,
                                       input logic [RW-1:0] ea3, input logic [TW-1:0] etn,
                                       input logic [RW-1:0] ma3, input logic [TW-1:0] mtn);
        if (tuse == '1) return 1'b0;
        return (hit(ea3, s) && (etn > tuse)) || (hit(ma3, s) && (mtn > tuse));
    endfunction

    // Nearest producer wins; a non-PC8 match in E either stalls or falls through.
    function automatic logic [2:0] d_fwd(input logic [RW-1:0] s,
                                         input logic [RW-1:0] ea3, input logic [1:0] esrc,
                                         input logic [RW-1:0] ma3, input logic [TW-1:0] mtn,
                                         input logic [1:0] msrc, input logic [RW-1:0] wa3);
        if (hit(ea3, s) && (esrc == SrcPc8)) return SelEpc;
        if (hit(ma3, s) && (mtn == '0)) return (msrc == SrcPc8) ? SelMpc : SelMalu;
        if (hit(wa3, s)) return SelWd;
        return SelRf;
    endfunction

    function automatic logic [2:0] e_fwd(input logic [RW-1:0] s,
                                         input logic [RW-1:0] ma3, input logic [1:0] msrc,
                                         input logic [RW-1:0] wa3);
        if (hit(ma3, s)) return (msrc == SrcPc8) ? SelMpc : SelMalu;
        if (hit(wa3, s)) return SelWd;
        return SelRf;
    endfunction

    // Advance records E->M->W; a stall turns the incoming E record into a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_a3   <= '0;
            e_rs   <= '0;
            e_rt   <= '0;
            e_tnew <= '0;
            e_src  <= '0;
            m_a3   <= '0;
            m_rt   <= '0;
            m_tnew <= '0;
            m_src  <= '0;
            w_a3   <= '0;
        end else begin
            if (stall) begin
                e_a3   <= '0;
                e_rs   <= '0;
                e_rt   <= '0;
                e_tnew <= '0;
                e_src  <= '0;
            end else begin
                e_a3   <= a3D;
                e_rs   <= rsD;
                e_rt   <= rtD;
                e_tnew <= tnewD;
                e_src  <= srcD;
            end
            m_a3   <= e_a3;
            m_rt   <= e_rt;
            m_tnew <= (e_tnew == '0) ? '0 : e_tnew - TW'(1);
            m_src  <= e_src;
            w_a3   <= m_a3;
        end
    end

`ifdef MD_STALL_EN
    logic [3:0] md_cnt;
    logic       e_valid;

    // Busy counter for the multiply/divide unit; only a real (non-bubble) E op starts it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt  <= '0;
            e_valid <= 1'b0;
        end else begin
            e_valid <= !stall;
            if ((md_startE != 2'b00) && e_valid) begin
                md_cnt <= md_startE[1] ? 4'd10 : 4'd5;
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - 4'd1;
            end
        end
    end

    // HI/LO users wait while an op is starting or still busy.
    always_comb begin
        md_stall = md_useD && ((md_cnt != '0) || (md_startE != 2'b00));
    end
`else
    // No multiply/divide interlock in this build.
    always_comb begin
        md_stall = 1'b0;
    end
`endif

    // Combinational stall and forward selects from the records and D inputs.
    always_comb begin
        stall = src_stall(rsD, tuse_rs, e_a3, e_tnew, m_a3, m_tnew)
              | src_stall(rtD, tuse_rt, e_a3, e_tnew, m_a3, m_tnew)
              | md_stall;
        mf_d_1_sel   = d_fwd(rsD, e_a3, e_src, m_a3, m_tnew, m_src, w_a3);
        mf_d_2_sel   = d_fwd(rtD, e_a3, e_src, m_a3, m_tnew, m_src, w_a3);
        mf_alu_a_sel = e_fwd(e_rs, m_a3, m_src, w_a3);
        mf_alu_b_sel = e_fwd(e_rt, m_a3, m_src, w_a3);
        mf_dmi_sel   = (w_a3 != '0) && (m_rt == w_a3) ? SelWd : SelRf;
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios plus a randomized
// stream compared against an age-based latency model of the pipeline.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD, a3D;
    logic [1:0] tuse_rs, tuse_rt, tnewD, srcD;
    logic       stall;
    logic [2:0] mf_d_1_sel, mf_d_2_sel, mf_alu_a_sel, mf_alu_b_sel, mf_dmi_sel;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_fwd_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .rsD          (rsD),
        .rtD          (rtD),
        .tuse_rs      (tuse_rs),
        .tuse_rt      (tuse_rt),
        .a3D          (a3D),
        .tnewD        (tnewD),
        .srcD         (srcD),
        .stall        (stall),
        .mf_d_1_sel   (mf_d_1_sel),
        .mf_d_2_sel   (mf_d_2_sel),
        .mf_alu_a_sel (mf_alu_a_sel),
        .mf_alu_b_sel (mf_alu_b_sel),
        .mf_dmi_sel   (mf_dmi_sel)
    );

    always #5 clk = ~clk;

    // Reference model: instructions in flight, index = age in stages past D (1=E, 2=M, 3=W).
    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [1:0] src;
        logic [4:0] rs;
        logic [4:0] rt;
    } ins_t;

    ins_t pipe [1:3];

    function automatic int rem_lat(input ins_t p, input int age);
        int r;
        if (age >= 3) return 0;
        r = int'(p.tnew) - (age - 1);
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit writes(input ins_t p, input logic [4:0] s);
        return (p.a3 != 5'd0) && (p.a3 == s);
    endfunction

    function automatic bit exp_src_stall(input logic [4:0] s, input logic [1:0] tuse);
        if (tuse == 2'd3) return 1'b0;
        for (int age = 1; age <= 2; age++)
            if (writes(pipe[age], s) && (rem_lat(pipe[age], age) > int'(tuse))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] exp_dsel(input logic [4:0] s);
        if (writes(pipe[1], s) && pipe[1].src == 2'b10) return 3'b100;
        if (writes(pipe[2], s) && rem_lat(pipe[2], 2) == 0)
            return (pipe[2].src == 2'b10) ? 3'b010 : 3'b001;
        if (writes(pipe[3], s)) return 3'b011;
        return 3'b000;
    endfunction

    function automatic logic [2:0] exp_esel(input logic [4:0] s);
        if (writes(pipe[2], s)) return (pipe[2].src == 2'b10) ? 3'b010 : 3'b001;
        if (writes(pipe[3], s)) return 3'b011;
        return 3'b000;
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tur,
                         input logic [1:0] tut, input logic [4:0] a3, input logic [1:0] tn,
                         input logic [1:0] sr);
        rsD = rs; rtD = rt; tuse_rs = tur; tuse_rt = tut; a3D = a3; tnewD = tn; srcD = sr;
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random();
        drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
              2'($urandom_range(0, 2)));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive_random();
        step();
        step();
        reset = 1'b1;
        nop();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_random();
        step();
        drive_random();
        step();
        reset = 1'b1;
        #2;
        n_tests++;
        if ({stall, mf_d_1_sel, mf_d_2_sel, mf_alu_a_sel, mf_alu_b_sel, mf_dmi_sel} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_release: got stall=%b d1=%b d2=%b a=%b b=%b dmi=%b, want all 0",
                     stall, mf_d_1_sel, mf_d_2_sel, mf_alu_a_sel, mf_alu_b_sel, mf_dmi_sel);
        end
        step();
    endtask

    task automatic test_alu_branch();
        do_reset();
        drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd1, 2'b00);
        #2;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_add_stall: got %b want 0", stall);
        end
        step();
        drive(5'd3, 5'd3, 2'd0, 2'd0, 5'd0, 2'd0, 2'b00);
        #2;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_beq_stall: got %b want 1", stall);
        end
        step();
        #2;
        n_tests++;
        if ({stall, mf_d_1_sel, mf_d_2_sel} !== 7'b0_001_001) begin
            n_fail++;
            $display("FAIL alu_beq_fwd: got stall=%b d1=%b d2=%b want 0/001/001",
                     stall, mf_d_1_sel, mf_d_2_sel);
        end
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(5'd1, 5'd0, 2'd1, 2'd3, 5'd5, 2'd2, 2'b01);
        step();
        drive(5'd5, 5'd5, 2'd1, 2'd1, 5'd6, 2'd1, 2'b00);
        #2;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b want 1", stall);
        end
        step();
        #2;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_release: got %b want 0", stall);
        end
        step();
        nop();
        #2;
        n_tests++;
        if ({mf_alu_a_sel, mf_alu_b_sel} !== 6'b011_011) begin
            n_fail++;
            $display("FAIL load_use_alu_fwd: got a=%b b=%b want 011/011",
                     mf_alu_a_sel, mf_alu_b_sel);
        end
        step();
    endtask

    task automatic test_jal_jr();
        do_reset();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 2'b10);
        step();
        drive(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'b00);
        #2;
        n_tests++;
        if ({stall, mf_d_1_sel} !== 4'b0_100) begin
            n_fail++;
            $display("FAIL jal_jr: got stall=%b d1=%b want 0/100", stall, mf_d_1_sel);
        end
        step();
    endtask

    task automatic test_load_store();
        do_reset();
        drive(5'd1, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 2'b01);
        step();
        drive(5'd2, 5'd8, 2'd1, 2'd2, 5'd0, 2'd0, 2'b00);
        #2;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_store_stall: got %b want 0", stall);
        end
        step();
        nop();
        step();
        #2;
        n_tests++;
        if (mf_dmi_sel !== 3'b011) begin
            n_fail++;
            $display("FAIL load_store_dmi: got %b want 011", mf_dmi_sel);
        end
        step();
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(5'd1, 5'd0, 2'd1, 2'd3, 5'd0, 2'd2, 2'b01);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'b00);
            #2;
            n_tests++;
            if ({stall, mf_d_1_sel, mf_d_2_sel, mf_alu_a_sel, mf_alu_b_sel, mf_dmi_sel}
                !== 16'd0) begin
                n_fail++;
                $display("FAIL zero_reg[%0d]: got stall=%b d1=%b d2=%b a=%b b=%b dmi=%b want 0",
                         i, stall, mf_d_1_sel, mf_d_2_sel, mf_alu_a_sel, mf_alu_b_sel,
                         mf_dmi_sel);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic       es;
        logic [2:0] ed1, ed2, ea, eb, edmi;
        ins_t       cur;
        do_reset();
        for (int k = 1; k <= 3; k++) pipe[k] = '0;
        for (int c = 0; c < 400; c++) begin
            drive_random();
            #2;
            es   = exp_src_stall(rsD, tuse_rs) | exp_src_stall(rtD, tuse_rt);
            ed1  = exp_dsel(rsD);
            ed2  = exp_dsel(rtD);
            ea   = exp_esel(pipe[1].rs);
            eb   = exp_esel(pipe[1].rt);
            edmi = writes(pipe[3], pipe[2].rt) ? 3'b011 : 3'b000;
            n_tests++;
            if (stall !== es) begin
                n_fail++;
                $display("FAIL rand_stall c=%0d: got %b want %b", c, stall, es);
            end
            n_tests++;
            if ({mf_d_1_sel, mf_d_2_sel} !== {ed1, ed2}) begin
                n_fail++;
                $display("FAIL rand_dsel c=%0d: got %b/%b want %b/%b",
                         c, mf_d_1_sel, mf_d_2_sel, ed1, ed2);
            end
            n_tests++;
            if ({mf_alu_a_sel, mf_alu_b_sel} !== {ea, eb}) begin
                n_fail++;
                $display("FAIL rand_alusel c=%0d: got %b/%b want %b/%b",
                         c, mf_alu_a_sel, mf_alu_b_sel, ea, eb);
            end
            n_tests++;
            if (mf_dmi_sel !== edmi) begin
                n_fail++;
                $display("FAIL rand_dmi c=%0d: got %b want %b", c, mf_dmi_sel, edmi);
            end
            cur = '{a3: a3D, tnew: tnewD, src: srcD, rs: rsD, rt: rtD};
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            pipe[1] = es ? ins_t'('0) : cur;
            step();
        end
    endtask

    initial begin
        reset = 1'b0;
        nop();
        #1;
        test_reset();
        test_alu_branch();
        test_load_use();
        test_jal_jr();
        test_load_store();
        test_zero_reg();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
